// File: rtl/fp_cvt.sv
// fp_cvt: 12-bit two's-complement integer to 8-bit floating-point code.
//
// Output code value = (-1)^S * F * 2^E, rounded to nearest (round half up
// on the first discarded bit), saturating at E=7, F=15. The conversion is
// purely combinational and is captured in the output register every clock.
//
// Ports:
//   clk  in   1   rising-edge clock
//   rst  in   1   synchronous active-high reset, clears S/E/F
//   D    in   12  two's-complement integer, -2048..2047
//   S    out  1   sign, registered
//   E    out  3   exponent 0..7, registered
//   F    out  4   significand 0..15, registered
module fp_cvt (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] D,
    output logic        S,
    output logic [2:0]  E,
    output logic [3:0]  F
);

    // Magnitude of the input. -2048 has no 11-bit magnitude and clamps to
    // 2047, which then saturates to the largest code.
    function automatic logic [10:0] magnitude(input logic signed [11:0] d);
        logic [11:0] neg;
        neg = 12'(~d + 12'sd1);
        if (!d[11])
            return d[10:0];
        else if (d == -12'sd2048)
            return 11'h7FF;
        else
            return neg[10:0];
    endfunction

    // Pre-round exponent: position of the leading one minus 3, so that the
    // leading one lands in F0[3]. Values below 16 keep E0=0 and are exact.
    function automatic logic [2:0] lead_exp(input logic [10:0] m);
        logic [2:0] e0;
        e0 = 3'd0;
        for (int i = 4; i <= 10; i++) begin
            if (m[i])
                e0 = 3'(i - 3);
        end
        return e0;
    endfunction

    // Round on the first discarded bit; a carry out of the significand
    // renormalises to 1000 with E+1, or saturates at the top exponent.
    function automatic logic [6:0] round_fp(input logic [10:0] m,
                                            input logic [2:0]  e0);
        logic [10:0] sh;
        logic [3:0]  f0;
        logic [3:0]  rpos;
        logic        r;
        logic [2:0]  e;
        logic [3:0]  f;
        sh   = m >> e0;
        f0   = sh[3:0];
        rpos = {1'b0, e0} - 4'd1;
        r    = (e0 != 3'd0) ? m[rpos] : 1'b0;
        e    = e0;
        f    = f0;
        if (r) begin
            if (f0 != 4'd15) begin
                f = f0 + 4'd1;
            end else if (e0 != 3'd7) begin
                f = 4'b1000;
                e = e0 + 3'd1;
            end else begin
                f = 4'd15;
                e = 3'd7;
            end
        end
        return {e, f};
    endfunction

    logic        s_p0;
    logic [10:0] mag_p0;
    logic [2:0]  e0_p0;
    logic [6:0]  ef_p0;

    logic        s_p1;
    logic [2:0]  e_p1;
    logic [3:0]  f_p1;

    // Stage p0: combinational conversion of the sampled input.
    always_comb begin
        s_p0   = D[11];
        mag_p0 = magnitude($signed(D));
        e0_p0  = lead_exp(mag_p0);
        ef_p0  = round_fp(mag_p0, e0_p0);
    end

    // Stage p1: output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_p1 <= 1'b0;
            e_p1 <= 3'd0;
            f_p1 <= 4'd0;
        end else begin
            s_p1 <= s_p0;
            e_p1 <= ef_p0[6:4];
            f_p1 <= ef_p0[3:0];
        end
    end

    assign S = s_p1;
    assign E = e_p1;
    assign F = f_p1;

endmodule

// File: tb/tb_fp_cvt.sv
// tb_fp_cvt: directed and exhaustive checking of fp_cvt.
module tb_fp_cvt;

    logic        clk;
    logic        rst;
    logic [11:0] D;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;

    int checks;
    int errors;

    fp_cvt dut (
        .clk (clk),
        .rst (rst),
        .D   (D),
        .S   (S),
        .E   (E),
        .F   (F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: finds the exponent by shifting until the significand
    // fits in four bits, then applies the rounding rules.
    function automatic logic [7:0] ref_cvt(input int d);
        int s, mag, e0, f0, r, e, f;
        logic [7:0] code;
        s   = (d < 0) ? 1 : 0;
        mag = (d < 0) ? -d : d;
        if (mag > 2047) mag = 2047;
        e0 = 0;
        while ((mag >> e0) > 15) e0++;
        f0 = mag >> e0;
        r  = (e0 > 0) ? ((mag >> (e0 - 1)) & 1) : 0;
        e  = e0;
        f  = f0;
        if (r == 1) begin
            if (f0 < 15) f = f0 + 1;
            else if (e0 < 7) begin f = 8; e = e0 + 1; end
            else begin f = 15; e = 7; end
        end
        code[7]   = s[0];
        code[6:4] = e[2:0];
        code[3:0] = f[3:0];
        return code;
    endfunction

    task automatic check_code(input string tag, input logic [7:0] exp_code);
        logic [7:0] obs;
        obs = {S, E, F};
        checks++;
        assert (obs === exp_code) else begin
            errors++;
            $error("FAIL %s: got S=%0d E=%0d F=%0d, expected S=%0d E=%0d F=%0d",
                   tag, obs[7], obs[6:4], obs[3:0],
                   exp_code[7], exp_code[6:4], exp_code[3:0]);
        end
    endtask

    // Apply one value, clock it in, and check the registered result.
    task automatic step(input string tag, input logic [11:0] d,
                        input logic s, input logic [2:0] e, input logic [3:0] f);
        D = d;
        @(posedge clk);
        #1;
        check_code(tag, {s, e, f});
    endtask

    initial begin
        int prev;
        int cur;
        int mag;
        int err;
        int half_ulp;
        int e0;
        logic [7:0] exp_code;
        logic [7:0] obs;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        D   = 12'h7FF;

        // Reset held for two edges with a nonzero input.
        @(posedge clk); #1;
        check_code("reset_1", 8'h00);
        @(posedge clk); #1;
        check_code("reset_2", 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;
        check_code("first_after_reset", {1'b0, 3'd7, 4'd15});

        // Exact and truncating cases.
        step("d105",  12'd105,  1'b0, 3'd3, 4'd13);
        step("d355",  12'd355,  1'b0, 3'd5, 4'd11);
        step("dm1",   12'hFFF,  1'b1, 3'd0, 4'd1);
        step("d0",    12'd0,    1'b0, 3'd0, 4'd0);
        step("d15",   12'd15,   1'b0, 3'd0, 4'd15);
        step("d16",   12'd16,   1'b0, 3'd1, 4'd8);

        // Round-up with significand overflow.
        step("d125",  12'd125,  1'b0, 3'd4, 4'd8);
        step("d511",  12'd511,  1'b0, 3'd6, 4'd8);
        step("dm511", 12'hE01,  1'b1, 3'd6, 4'd8);

        // Saturation.
        step("d2047", 12'd2047, 1'b0, 3'd7, 4'd15);
        step("d1984", 12'd1984, 1'b0, 3'd7, 4'd15);
        step("dm2048",12'h800,  1'b1, 3'd7, 4'd15);

        // Simple round-up at the top exponent.
        step("d1344", 12'd1344, 1'b0, 3'd7, 4'd11);

        // Input changing between edges has no effect until the next edge.
        D = 12'd105;
        @(posedge clk); #1;
        D = 12'd2047;
        #3;
        check_code("hold_between_edges", {1'b0, 3'd3, 4'd13});

        // Reset in mid-stream takes priority over the sampled input.
        rst = 1'b1;
        D   = 12'd355;
        @(posedge clk); #1;
        check_code("mid_reset", 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;
        check_code("after_mid_reset", {1'b0, 3'd5, 4'd11});

        // Exhaustive sweep, one value per cycle, result checked one edge later.
        D    = 12'd0;
        prev = 0;
        for (int i = 1; i <= 4096; i++) begin
            @(posedge clk); #1;
            exp_code = ref_cvt(prev);
            check_code($sformatf("sweep_%0d", prev), exp_code);

            // Error bound: at most half an ulp of the pre-round exponent,
            // except in the saturated region.
            obs = {S, E, F};
            mag = (prev < 0) ? -prev : prev;
            if (mag > 2047) mag = 2047;
            e0 = 0;
            while ((mag >> e0) > 15) e0++;
            half_ulp = (e0 > 0) ? (1 << (e0 - 1)) : 0;
            err = (int'(obs[3:0]) << obs[6:4]) - mag;
            if (err < 0) err = -err;
            if (mag < 1984) begin
                checks++;
                assert (err <= half_ulp) else begin
                    errors++;
                    $error("FAIL err_bound_%0d: error %0d, bound %0d", prev, err, half_ulp);
                end
            end

            if (i < 4096) begin
                cur  = (i >= 2048) ? i - 4096 : i;
                D    = 12'(i);
                prev = cur;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_cvt.md
# fp_cvt

Converts a 12-bit two's-complement integer into an 8-bit sign/exponent/significand floating-point code (value = (−1)^S · F · 2^E), rounding to nearest. It is a registered datapath block between an integer source and a compact floating-point consumer. Conversion is purely combinational internally; the result is captured in an output register every clock.

## Interface
- No parameters; all widths are fixed.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `D`  input  12  two's-complement integer to convert, range −2048..2047.
- `S`  output  1  sign bit, registered.
- `E`  output  3  exponent 0..7, registered.
- `F`  output  4  significand 0..15, registered.
- One clock; reset is synchronous and active-high.

## Operation
- Sign: S = D[11].
- Magnitude: M = D if D[11]=0, else −D (two's complement).
- D = 12'b100000000000 (−2048) has no 11-bit magnitude. It clamps to M = 2047, which yields S=1, E=7, F=15.
- Leading zeros: count leading zeros Z of the 12-bit M. M[11] is always 0, so Z ≥ 1.
- Exponent (pre-round):
  - E0 = 8 − Z for Z ≤ 7.
  - E0 = 0 for Z ≥ 8, including M = 0.
- Significand (pre-round):
  - E0 > 0: F0 = M[E0+3 : E0], the leading 1 and the next three bits. Round bit R = M[E0−1].
  - E0 = 0: F0 = M[3:0] and R = 0.
- Rounding (round half up on the first discarded bit only):
  - R=0: F=F0, E=E0.
  - R=1 and F0<15: F=F0+1, E=E0.
  - R=1, F0=15 and E0<7: F=4'b1000, E=E0+1.
  - R=1, F0=15 and E0=7: saturate, F=15, E=7.
- Negative inputs use the same E/F as their magnitude. There is no negative zero: D=0 gives S=0, E=0, F=0.

## Timing
- On each rising clk edge with rst=0: {S,E,F} ← convert(D). D is sampled at that edge.
- Latency: 1 cycle.
- Throughput: one conversion per cycle; no handshake and no stall.
- Reset (rst=1 at a rising edge): S=0, E=0, F=0. Reset takes priority over the sampled D.
- The first valid result appears at the first edge after rst deasserts.
- Outputs hold their value between edges. D changing between edges has no effect until the next edge.
- No internal state beyond the output register. Reset in the middle of a stream only clears the output register.

## Test plan
- Reset: assert rst for 2 cycles with D=12'h7FF. Required: S=0, E=0, F=0. The first edge after release gives S=0, E=7, F=15.
- Exact and truncating cases. One edge after each D:
  - D=105 (000001101001) → S=0, E=3, F=13.
  - D=355 (000101100011) → S=0, E=5, F=11.
  - D=−1 (111111111111) → S=1, E=0, F=1.
  - D=0 → S=0, E=0, F=0.
- Round-up with significand overflow:
  - D=125 (000001111101) → E=4, F=8.
  - D=511 (000111111111) → E=6, F=8.
  - D=−511 (111000000001) → S=1, E=6, F=8.
- Saturation:
  - D=2047 → E=7, F=15.
  - D=1984 (011111000000) → E=7, F=15.
  - D=−2048 (100000000000) → S=1, E=7, F=15.
- Simple round-up: D=1344 (010101000000) → S=0, E=7, F=11.
- Exhaustive check: sweep all 4096 values of D back to back, one per cycle. Compare each output, delayed one cycle, against a reference model of the rules above. Confirm |F·2^E − |D|| is minimal under the stated rounding and saturation rules.
